// File: rtl/neuromorphic_x1_arbiter.sv
// neuromorphic_x1_arbiter: two-port round-robin arbiter sequencing accesses onto the
// NEUROMORPHIC_X1 functional port, holding EN until func_ack or a bounded timeout.
module neuromorphic_x1_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_rw,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_sel,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_rw,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_sel,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        mac_en,
  output logic        mac_r_wb,
  output logic [31:0] mac_di,
  output logic [31:0] mac_ad,
  output logic [3:0]  mac_sel,
  input  logic [31:0] mac_do,
  input  logic        mac_ack,
  output logic        busy,
  output logic [7:0]  timeout_count
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t      r_state, w_next;
  logic        r_last, r_owner;
  logic [15:0] r_cnt;
  logic        w_grant0, w_grant1, w_accept, w_end, w_tmo;
  logic [31:0] w_rdata;
  // r_last = 1 means port 1 won the previous grant, so port 0 takes the next tie
  assign w_grant1   = req1_valid & (~req0_valid | ~r_last);
  assign w_grant0   = req0_valid & ~w_grant1;
  assign req0_ready = RSTin & (r_state == S_IDLE) & w_grant0;
  assign req1_ready = RSTin & (r_state == S_IDLE) & w_grant1;
  assign w_accept   = req0_ready | req1_ready;
  assign w_tmo      = r_cnt == TMO_LAST;
  assign w_end      = mac_ack | w_tmo;
  assign w_rdata    = (mac_ack & mac_r_wb) ? mac_do : 32'd0;
  assign mac_en     = r_state == S_BUSY;
  assign busy       = r_state != S_IDLE;
  assign req0_done  = (r_state == S_DONE) & ~r_owner;
  assign req1_done  = (r_state == S_DONE) & r_owner;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_BUSY : S_IDLE;
      S_BUSY:  w_next = w_end ? S_DONE : S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      r_last        <= 1'b1;
      r_owner       <= 1'b0;
      r_cnt         <= 16'd0;
      mac_r_wb      <= 1'b1;
      mac_di        <= 32'd0;
      mac_ad        <= 32'd0;
      mac_sel       <= 4'd0;
      req0_rdata    <= 32'd0;
      req0_err      <= 1'b0;
      req1_rdata    <= 32'd0;
      req1_err      <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_owner  <= req1_ready;
        r_last   <= req1_ready;
        mac_r_wb <= req1_ready ? req1_rw    : req0_rw;
        mac_di   <= req1_ready ? req1_wdata : req0_wdata;
        mac_ad   <= req1_ready ? req1_addr  : req0_addr;
        mac_sel  <= req1_ready ? req1_sel   : req0_sel;
      end
      r_cnt <= (r_state == S_BUSY) ? r_cnt + 16'd1 : 16'd0;
      if (r_state == S_BUSY && w_end) begin
        if (r_owner) begin
          req1_rdata <= w_rdata;
          req1_err   <= ~mac_ack;
        end else begin
          req0_rdata <= w_rdata;
          req0_err   <= ~mac_ack;
        end
        if (!mac_ack && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_neuromorphic_x1_arbiter.sv
// tb_neuromorphic_x1_arbiter: directed stimulus with a transaction-level reference model
// compared every cycle, plus literal expectations from the hand-worked scenarios.
module tb_neuromorphic_x1_arbiter;
  localparam int TO = 8;
  logic CLKin = 0, RSTin = 0;
  logic req0_valid = 0, req0_ready, req0_rw = 0, req0_done, req0_err;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req0_rdata;
  logic [3:0] req0_sel = 0;
  logic req1_valid = 0, req1_ready, req1_rw = 0, req1_done, req1_err;
  logic [31:0] req1_addr = 0, req1_wdata = 0, req1_rdata;
  logic [3:0] req1_sel = 0;
  logic mac_en, mac_r_wb, mac_ack = 0, busy;
  logic [31:0] mac_di, mac_ad, mac_do = 0;
  logic [3:0] mac_sel;
  logic [7:0] timeout_count;

  neuromorphic_x1_arbiter #(.TIMEOUT(TO)) dut (
    .CLKin(CLKin), .RSTin(RSTin),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_sel(req0_sel), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_sel(req1_sel), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .mac_en(mac_en), .mac_r_wb(mac_r_wb), .mac_di(mac_di), .mac_ad(mac_ad), .mac_sel(mac_sel),
    .mac_do(mac_do), .mac_ack(mac_ack), .busy(busy), .timeout_count(timeout_count)
  );

  always #5 CLKin = ~CLKin;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one access at a time, tracked as "in flight" / "completing"
  bit m_busy = 0, m_done = 0, m_owner = 0, m_last = 1, m_rw = 1;
  int m_en = 0, m_tcnt = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0] m_sel = 0;
  logic [31:0] m_rdata [2] = '{32'd0, 32'd0};
  bit m_err [2] = '{1'b0, 1'b0};

  initial forever begin
    bit e0, e1;
    @(negedge CLKin);
    if (!RSTin) begin
      m_busy = 0; m_done = 0; m_last = 1; m_tcnt = 0;
      m_rdata[0] = 0; m_rdata[1] = 0; m_err[0] = 0; m_err[1] = 0;
    end
    e0 = RSTin && !m_busy && !m_done && req0_valid && (!req1_valid || m_last);
    e1 = RSTin && !m_busy && !m_done && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("req0_done", req0_done, m_done && !m_owner);
    chk("req1_done", req1_done, m_done && m_owner);
    chk("req0_rdata", req0_rdata, m_rdata[0]);
    chk("req1_rdata", req1_rdata, m_rdata[1]);
    chk("req0_err", req0_err, m_err[0]);
    chk("req1_err", req1_err, m_err[1]);
    chk("mac_en", mac_en, m_busy);
    chk("busy", busy, m_busy || m_done);
    chk("timeout_count", timeout_count, m_tcnt);
    if (m_busy) begin
      chk("mac_r_wb", mac_r_wb, m_rw);
      chk("mac_ad", mac_ad, m_addr);
      chk("mac_di", mac_di, m_wdata);
      chk("mac_sel", mac_sel, m_sel);
    end
    if (RSTin) begin
      if (m_done) m_done = 0;
      else if (m_busy) begin
        m_en++;
        if (mac_ack) begin
          m_rdata[m_owner] = m_rw ? mac_do : 32'd0;
          m_err[m_owner] = 0; m_busy = 0; m_done = 1;
        end else if (m_en == TO) begin
          m_rdata[m_owner] = 0; m_err[m_owner] = 1; m_busy = 0; m_done = 1;
          if (m_tcnt < 255) m_tcnt++;
        end
      end else if (e0 || e1) begin
        m_owner = e1; m_last = e1;
        m_rw = e1 ? req1_rw : req0_rw;
        m_addr = e1 ? req1_addr : req0_addr;
        m_wdata = e1 ? req1_wdata : req0_wdata;
        m_sel = e1 ? req1_sel : req0_sel;
        m_busy = 1; m_en = 0;
      end
    end
  end

  // Macro responder: ack after ack_delay EN cycles (0 = never); stray forces ack
  int ack_delay = 1, en_run = 0;
  bit stray = 0;
  initial forever begin
    @(posedge CLKin); #1;
    en_run = mac_en ? en_run + 1 : 0;
    mac_ack = stray | (mac_en && ack_delay != 0 && en_run == ack_delay);
  end

  int cyc = 0, run_len = 0, last_len = 0, done_cnt = 0;
  int acc_cyc[$], acc_port[$];
  initial forever begin
    @(negedge CLKin);
    cyc++;
    if (mac_en) run_len++;
    else if (run_len > 0) begin last_len = run_len; run_len = 0; end
    done_cnt += int'(req0_done) + int'(req1_done);
    if (req0_ready | req1_ready) begin acc_cyc.push_back(cyc); acc_port.push_back(int'(req1_ready)); end
  end

  task automatic issue(input int p, input bit rw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s);
    bit acc = 0;
    @(posedge CLKin); #1;
    if (p == 0) begin req0_rw = rw; req0_addr = a; req0_wdata = wd; req0_sel = s; req0_valid = 1; end
    else begin req1_rw = rw; req1_addr = a; req1_wdata = wd; req1_sel = s; req1_valid = 1; end
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge CLKin);
      acc = (p == 0) ? req0_ready : req1_ready;
    end
    @(posedge CLKin); #1;
    if (p == 0) req0_valid = 0; else req1_valid = 0;
    chk("accepted", acc, 1);
  endtask

  task automatic wait_done(input int p, output logic [31:0] rd, output logic er, output int len);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLKin);
      seen = (p == 0) ? req0_done : req1_done;
    end
    rd = (p == 0) ? req0_rdata : req1_rdata;
    er = (p == 0) ? req0_err : req1_err;
    #1 len = last_len;
    chk("done_seen", seen, 1);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int len, d;
    req0_valid = 1;
    @(negedge CLKin);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_r_wb", mac_r_wb, 1);
    chk("rst_mac_ad", mac_ad, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tcnt", timeout_count, 0);
    req0_valid = 0;
    @(negedge CLKin); #2 RSTin = 1;

    // single read, port 0
    ack_delay = 3; mac_do = 32'hA5A5_1234; d = done_cnt;
    issue(0, 1, 32'h10, 0, 4'hF);
    wait_done(0, rd, er, len);
    chk("rd_rdata", rd, 32'hA5A5_1234);
    chk("rd_err", er, 0);
    chk("rd_en_len", len, 3);
    @(negedge CLKin);
    chk("rd_one_pulse", done_cnt - d, 1);

    // single write, port 1
    ack_delay = 2;
    issue(1, 0, 32'h1F, 32'hDEAD_BEEF, 4'hF);
    @(negedge CLKin);
    chk("wr_en", mac_en, 1);
    chk("wr_r_wb", mac_r_wb, 0);
    chk("wr_di", mac_di, 32'hDEAD_BEEF);
    chk("wr_ad", mac_ad, 32'h1F);
    chk("wr_sel", mac_sel, 4'hF);
    wait_done(1, rd, er, len);
    chk("wr_rdata", rd, 0);
    chk("wr_err", er, 0);

    // both ports contending
    ack_delay = 1; acc_cyc.delete(); acc_port.delete();
    fork
      begin issue(0, 1, 32'h100, 0, 4'h1); issue(0, 1, 32'h104, 0, 4'h1); end
      begin issue(1, 1, 32'h200, 0, 4'h2); issue(1, 1, 32'h204, 0, 4'h2); end
    join
    wait_done(1, rd, er, len);
    chk("rr_count", acc_port.size(), 4);
    if (acc_port.size() == 4) begin
      chk("rr_g0", acc_port[0], 0);
      chk("rr_g1", acc_port[1], 1);
      chk("rr_g2", acc_port[2], 0);
      chk("rr_g3", acc_port[3], 1);
      for (int i = 1; i < 4; i++) chk("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    end

    // timeout, then a normal follow-up
    ack_delay = 0;
    issue(0, 1, 32'h20, 0, 4'hF);
    wait_done(0, rd, er, len);
    chk("to_err", er, 1);
    chk("to_rdata", rd, 0);
    chk("to_en_len", len, TO);
    chk("to_count", timeout_count, 1);
    ack_delay = 2; mac_do = 32'h1234_5678;
    issue(0, 1, 32'h24, 0, 4'hF);
    wait_done(0, rd, er, len);
    chk("fu_err", er, 0);
    chk("fu_rdata", rd, 32'h1234_5678);

    // ack exactly on the timeout boundary
    ack_delay = TO; mac_do = 32'hCAFE_0001;
    issue(1, 1, 32'h30, 0, 4'hF);
    wait_done(1, rd, er, len);
    chk("bd_err", er, 0);
    chk("bd_rdata", rd, 32'hCAFE_0001);
    chk("bd_en_len", len, TO);
    chk("bd_count", timeout_count, 1);

    // stray ack while idle
    d = done_cnt;
    @(posedge CLKin); #1 stray = 1;
    repeat (3) @(posedge CLKin);
    #1 stray = 0;
    @(negedge CLKin);
    chk("stray_done", done_cnt - d, 0);
    chk("stray_busy", busy, 0);

    // reset during BUSY, then tie goes to port 0
    ack_delay = 0;
    issue(0, 1, 32'h40, 0, 4'hF);
    @(posedge CLKin); #3 RSTin = 0;
    #1 chk("arst_en", mac_en, 0);
    chk("arst_busy", busy, 0);
    d = done_cnt;
    repeat (3) @(negedge CLKin);
    #2 RSTin = 1;
    chk("arst_no_done", done_cnt - d, 0);
    ack_delay = 1; acc_cyc.delete(); acc_port.delete();
    fork
      issue(0, 1, 32'h50, 0, 4'hF);
      issue(1, 1, 32'h60, 0, 4'hF);
    join
    wait_done(1, rd, er, len);
    chk("arst_first_port", (acc_port.size() > 0) ? acc_port[0] : -1, 0);
    chk("arst_tcnt", timeout_count, 0);

    // saturation of the timeout counter
    ack_delay = 0;
    for (int i = 0; i < 300; i++) begin
      issue(1, 0, i, 0, 4'hF);
      wait_done(1, rd, er, len);
    end
    chk("sat_count", timeout_count, 255);
    chk("sat_err", er, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neuromorphic_x1_arbiter.md
# neuromorphic_x1_arbiter

Two-requester round-robin arbiter and transaction sequencer for the NEUROMORPHIC_X1 32x32 macro. It sits between the macro's functional port (EN, R_WB, DI, AD, SEL, DO, func_ack) and two independent masters, typically the Wishbone slave bridge (port 0) and an on-chip inference/DMA engine (port 1). It serialises their accesses, holds EN until func_ack, and bounds every access with a timeout so a hung macro cannot stall the bus.

## Interface
- TIMEOUT, 1023: max BUSY cycles waiting for func_ack before an access is aborted; range 1..65535.
- CLKin  in  1  clock, all logic rising-edge.
- RSTin  in  1  reset, asynchronous assert, active-low.
- req0_valid / req1_valid  in  1  access request, held until accepted.
- req0_ready / req1_ready  out  1  combinational; transfer when valid & ready.
- reqN_rw  in  1  1 = read, 0 = write (per port N).
- reqN_addr  in  32  macro address.
- reqN_wdata  in  32  write data.
- reqN_sel  in  4  byte select.
- reqN_done  out  1  one-cycle completion pulse.
- reqN_rdata  out  32  read data, valid while reqN_done = 1.
- reqN_err  out  1  timeout flag, valid while reqN_done = 1.
- mac_en  out  1  to macro EN.
- mac_r_wb  out  1  to macro R_WB.
- mac_di  out  32  to macro DI.
- mac_ad  out  32  to macro AD.
- mac_sel  out  4  to macro SEL.
- mac_do  in  32  from macro DO.
- mac_ack  in  1  from macro func_ack.
- busy  out  1  high in BUSY and DONE.
- timeout_count  out  8  saturating count of timed-out accesses.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any reqN_valid, arbiter picks winner and raises only that port's ready. Accept captures rw/addr/wdata/sel into mac_* registers, records owner; next state BUSY.
- Round robin: a single request wins immediately. On simultaneous requests, the port not granted last wins. After reset, last_grant = 1, so port 0 wins the first tie.
- BUSY: mac_en = 1; mac_r_wb/di/ad/sel stable at captured values. Timeout counter increments every BUSY cycle.
  - If mac_ack = 1: capture mac_do (reads) or 0 (writes) into owner's rdata; err = 0; go DONE.
  - Else if counter == TIMEOUT - 1: rdata = 0, err = 1, timeout_count += 1 (saturating at 255); go DONE.
  - If ack and timeout coincide, ack wins, err = 0.
- DONE: mac_en = 0; owner's reqN_done = 1 for exactly this cycle; counter cleared; go IDLE.
- mac_ack outside BUSY is ignored.
- Requests are never dropped. A valid not accepted stays pending; ready never rises outside IDLE.
- Non-owner done/err stay 0. reqN_rdata/err hold their last value after done.

## Timing
- Reset (RSTin = 0, asynchronous) forces these values:
  - State: IDLE.
  - Outputs: mac_en = 0, mac_r_wb = 1, mac_di = 0, mac_ad = 0, mac_sel = 0; all ready/done/err = 0, rdata = 0; busy = 0, timeout_count = 0; last_grant = 1.
- Reset mid-access drops mac_en the same instant. No done is issued for the aborted access.
- Accept at cycle T: mac_en = 1 from T+1. If ack is sampled at T+k (k ≥ 1), mac_en = 0 and done = 1 at T+k+1. IDLE resumes at T+k+2, so the next accept can happen at T+k+2.
- Minimum issue period: 3 cycles (accept, one BUSY, DONE).
- Timeout: with no ack, mac_en is high for exactly TIMEOUT cycles; done with err = 1 follows on the next cycle.
- EN is low for at least one cycle between consecutive accesses; the macro sees a fresh EN rising edge each access.

## Test plan
- Single read, port 0, addr 0x0000_0010, ack after 3 BUSY cycles with mac_do = 0xA5A5_1234 -> mac_en high exactly 3 cycles, req0_done one pulse, req0_rdata = 0xA5A5_1234, err = 0.
- Single write, port 1, addr 0x1F, wdata 0xDEAD_BEEF, sel 0xF -> mac_r_wb = 0, mac_di/ad/sel stable while mac_en = 1, req1_done with rdata = 0, err = 0.
- Both valid continuously for 4 accesses, ack after 1 cycle -> grants 0,1,0,1; accepts spaced exactly 3 cycles.
- TIMEOUT = 8, never ack -> mac_en high 8 cycles, done with err = 1, rdata = 0, timeout_count = 1. A follow-up access with ack completes normally. 300 timeouts leave timeout_count = 255.
- Ack on the same cycle as the timeout boundary -> err = 0, data captured, timeout_count unchanged. A stray mac_ack in IDLE -> no done, state unchanged.
- RSTin low during BUSY -> mac_en drops asynchronously, no done. After release, port 0 wins a tie first.
